// File: rtl/crc_rr_checker_if.sv
// Channel-side and result-side bundle for crc_rr_checker.
//   in_valid  : per-channel word available
//   in_ready  : one-hot grant from the checker
//   in_data   : channel i word at [i*DATA_W +: DATA_W]
//   in_crc    : channel i received CRC at [i*CRC_W +: CRC_W]
//   res_valid : one-cycle result strobe
//   res_chan  : channel the result belongs to
//   res_ok    : 1 when recomputed CRC equals received CRC
// master = channel sources / monitor, slave = checker.
interface crc_rr_checker_if #(
  parameter int unsigned NCH    = 16,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CRC_W  = 4
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH*CRC_W-1:0]  in_crc;
  logic                  res_valid;
  logic [CH_W-1:0]       res_chan;
  logic                  res_ok;

  modport master (
    output in_valid, in_data, in_crc,
    input  in_ready, res_valid, res_chan, res_ok
  );

  modport slave (
    input  in_valid, in_data, in_crc,
    output in_ready, res_valid, res_chan, res_ok
  );
endinterface

// File: rtl/crc_rr_checker.sv
// Multi-channel CRC checker with round-robin arbitration.
// Accepts one word at a time from NCH channels, recomputes its CRC serially
// at BPC bits per cycle (init 0, MSB-first, no reflection, no final XOR),
// reports pass/fail and keeps a saturating mismatch counter per channel.
// Ports:
//   clock_i     : clock, rising edge
//   reset_i     : synchronous active-high reset
//   clear_cnt_i : zero all error counters (wins over a coincident increment)
//   bus         : channel handshake and result strobe (crc_rr_checker_if.slave)
//   err_count_o : channel i counter at [i*CNT_W +: CNT_W]
module crc_rr_checker #(
  parameter int unsigned     NCH    = 16,
  parameter int unsigned     DATA_W = 64,
  parameter int unsigned     CRC_W  = 4,
  parameter logic [CRC_W-1:0] POLY  = 4'h3,
  parameter int unsigned     BPC    = 4,
  parameter int unsigned     CNT_W  = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   clear_cnt_i,
  crc_rr_checker_if.slave        bus,
  output logic [NCH*CNT_W-1:0]   err_count_o
);

  localparam int unsigned     CH_W    = $clog2(NCH);
  localparam int unsigned     NFOLD   = DATA_W / BPC;
  localparam int unsigned     FC_W    = $clog2(NFOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [CH_W-1:0]    ptr_q;
  logic [CH_W-1:0]    chan_q;
  logic [DATA_W-1:0]  data_q;
  logic [CRC_W-1:0]   rcrc_q;
  logic [CRC_W-1:0]   crc_q;
  logic [FC_W-1:0]    fold_q;
  logic               res_valid_q;
  logic [CH_W-1:0]    res_chan_q;
  logic               res_ok_q;
  logic [CNT_W-1:0]   cnt_q [NCH];

  logic               found_c;
  logic [CH_W-1:0]    gidx_c;
  logic [CH_W-1:0]    idx_v;
  logic [NCH-1:0]     grant_c;

  // Fold BPC message bits into the CRC, MSB first.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] crc_in,
                                                input logic [BPC-1:0]   bits);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = int'(BPC) - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ bits[i];
      c  = (c << 1) ^ ({CRC_W{fb}} & POLY);
    end
    return c;
  endfunction

  // Round-robin search: first valid channel after the last granted one.
  always_comb begin
    found_c = 1'b0;
    gidx_c  = '0;
    idx_v   = '0;
    grant_c = '0;
    for (int unsigned off = 1; off <= NCH; off++) begin
      idx_v = CH_W'((32'(ptr_q) + off) % NCH);
      if (!found_c && bus.in_valid[idx_v]) begin
        found_c = 1'b1;
        gidx_c  = idx_v;
      end
    end
    if (state_q == IDLE && found_c) begin
      grant_c[gidx_c] = 1'b1;
    end
  end

  assign bus.in_ready  = grant_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_chan  = res_chan_q;
  assign bus.res_ok    = res_ok_q;

  // Control FSM, datapath and counters.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= CH_W'(NCH - 1);
      chan_q      <= '0;
      data_q      <= '0;
      rcrc_q      <= '0;
      crc_q       <= '0;
      fold_q      <= '0;
      res_valid_q <= 1'b0;
      res_chan_q  <= '0;
      res_ok_q    <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_c) begin
            data_q  <= bus.in_data[gidx_c*DATA_W +: DATA_W];
            rcrc_q  <= bus.in_crc[gidx_c*CRC_W +: CRC_W];
            chan_q  <= gidx_c;
            ptr_q   <= gidx_c;
            crc_q   <= '0;
            fold_q  <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          crc_q  <= crc_fold(crc_q, data_q[DATA_W-1 -: BPC]);
          data_q <= data_q << BPC;
          fold_q <= fold_q + FC_W'(1);
          if (fold_q == FC_W'(NFOLD - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          res_valid_q <= 1'b1;
          res_chan_q  <= chan_q;
          res_ok_q    <= (crc_q == rcrc_q);
          if (crc_q != rcrc_q && cnt_q[chan_q] != CNT_MAX) begin
            cnt_q[chan_q] <= cnt_q[chan_q] + CNT_W'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Later assignment overrides any increment above.
      if (clear_cnt_i) begin
        for (int i = 0; i < int'(NCH); i++) begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    err_count_o = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      err_count_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_crc_rr_checker.sv
// Scoreboard bench for crc_rr_checker: drivers push expected results,
// a negedge monitor pops and compares each res_valid strobe.
module tb_crc_rr_checker;
  localparam int unsigned NCH    = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CRC_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef struct {
    logic [3:0] chan;
    logic       ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [NCH*CNT_W-1:0] err_count;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_acc = 0;
  longint cyc   = 0;
  exp_t   sbq[$];
  longint accq[$];

  // CRC-4 (x^4+x+1) of the 4-bit value v placed at bits [3:0]; worked by hand.
  logic [3:0] crc_tab [16] = '{4'h0, 4'h3, 4'h6, 4'h5, 4'hC, 4'hF, 4'hA, 4'h9,
                               4'hB, 4'h8, 4'hD, 4'hE, 4'h7, 4'h4, 4'h1, 4'h2};

  crc_rr_checker_if #(.NCH(NCH), .DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

  crc_rr_checker #(
    .NCH(NCH), .DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(4'h3), .BPC(4), .CNT_W(CNT_W)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .clear_cnt_i(clr),
    .bus        (bus),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare results against the scoreboard, record accept edges.
  always @(negedge clk) begin
    exp_t   e;
    longint t;
    if (bus.res_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result actual=chan%0d ok%0d required=no result",
                 bus.res_chan, bus.res_ok);
      end else begin
        e = sbq.pop_front();
        chk("res_chan", 128'(bus.res_chan), 128'(e.chan));
        chk("res_ok", 128'(bus.res_ok), 128'(e.ok));
        if (accq.size() > 0) begin
          t = accq.pop_front();
          chk("latency", 128'(cyc - t), 128'(17));
        end
      end
    end
    if (!rst && (bus.in_valid & bus.in_ready) != '0) begin
      accq.push_back(cyc + 1);
      n_acc++;
    end
  end

  task automatic push_exp(input int ch, input logic ok);
    exp_t e;
    e.chan = 4'(ch);
    e.ok   = ok;
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input int ch);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready[ch] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready[ch]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout ch%0d actual=no grant required=grant", ch);
    end
  endtask

  task automatic send_one(input int ch, input logic [63:0] d, input logic [3:0] c,
                          input logic ok);
    push_exp(ch, ok);
    bus.in_data[ch*DATA_W +: DATA_W] = d;
    bus.in_crc[ch*CRC_W +: CRC_W]    = c;
    bus.in_valid[ch]                 = 1'b1;
    wait_grant(ch);
    @(posedge clk); #1;
    bus.in_valid[ch] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
      accq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = '0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    accq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(0));
    chk({tag, "_res_valid"}, 128'(bus.res_valid), 128'(0));
    chk({tag, "_res_chan"}, 128'(bus.res_chan), 128'(0));
    chk({tag, "_res_ok"}, 128'(bus.res_ok), 128'(0));
    chk({tag, "_err_count"}, 128'(err_count), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] m3;
    int           base;
    int           n;

    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_crc   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: ch0, data 1, crc 3 -> pass.
    push_exp(0, 1'b1);
    bus.in_data[0 +: DATA_W] = 64'h1;
    bus.in_crc[0 +: CRC_W]   = 4'h3;
    bus.in_valid[0]          = 1'b1;
    @(negedge clk);
    chk("t1_in_ready", 128'(bus.in_ready), 128'(16'h0001));
    @(posedge clk); #1;
    bus.in_valid[0] = 1'b0;
    drain(40);
    chk("t1_err0", 128'(err_count[0 +: CNT_W]), 128'(0));

    // Test 2: ch5, data 2, wrong crc 0 (correct 6); ch1 valid only while busy.
    send_one(5, 64'h2, 4'h0, 1'b0);
    bus.in_data[1*DATA_W +: DATA_W] = 64'h1;
    bus.in_crc[1*CRC_W +: CRC_W]    = 4'h3;
    bus.in_valid[1]                 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_busy_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    bus.in_valid[1] = 1'b0;
    drain(40);
    chk("t2_err5", 128'(err_count[5*CNT_W +: CNT_W]), 128'(1));
    chk("t2_err1", 128'(err_count[1*CNT_W +: CNT_W]), 128'(0));

    // Test 3: all channels valid after reset -> order 0..15,0.
    do_reset();
    for (int ch = 0; ch < int'(NCH); ch++) begin
      bus.in_data[ch*DATA_W +: DATA_W] = 64'(ch) << 60;
      bus.in_crc[ch*CRC_W +: CRC_W]    = crc_tab[ch];
    end
    for (int k = 0; k < 17; k++) push_exp(k % int'(NCH), 1'b1);
    base = n_acc;
    bus.in_valid = '1;
    n = 0;
    while (n_acc < base + 17 && n < 17 * 18 + 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_accepts", 128'(n_acc - base), 128'(17));
    @(posedge clk); #1;
    bus.in_valid = '0;
    drain(60);
    chk("t3_err_all", 128'(err_count), 128'(0));

    // Test 6: ch2 at count 4, clear_cnt during the DONE cycle of a mismatch.
    for (int k = 0; k < 4; k++) send_one(2, 64'h1, 4'h0, 1'b0);
    drain(40);
    chk("t6_err2_4", 128'(err_count[2*CNT_W +: CNT_W]), 128'(4));
    send_one(2, 64'h1, 4'h0, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    chk("t6_pre_clear", 128'(err_count[2*CNT_W +: CNT_W]), 128'(4));
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("t6_cleared", 128'(err_count), 128'(0));
    drain(10);

    // Test 4: ch3 300 bad words -> saturates at 255.
    for (int k = 0; k < 255; k++) send_one(3, 64'h8000_0000_0000_0000, 4'h0, 1'b0);
    drain(40);
    chk("t4_err3_255", 128'(err_count[3*CNT_W +: CNT_W]), 128'(255));
    for (int k = 0; k < 45; k++) send_one(3, 64'h8000_0000_0000_0000, 4'h0, 1'b0);
    drain(40);
    chk("t4_err3_sat", 128'(err_count[3*CNT_W +: CNT_W]), 128'(255));
    m3 = '0;
    m3[3*CNT_W +: CNT_W] = '1;
    chk("t4_err_others", 128'(err_count) & ~m3, 128'(0));

    // Test 5: reset mid-CALC on ch7, then ch0 and ch7 valid together.
    bus.in_data[7*DATA_W +: DATA_W] = 64'h4;
    bus.in_crc[7*CRC_W +: CRC_W]    = 4'hC;
    bus.in_valid[7]                 = 1'b1;
    wait_grant(7);
    @(posedge clk); #1;
    bus.in_valid[7] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("t5_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    accq.delete();
    repeat (30) @(negedge clk);
    push_exp(0, 1'b1);
    push_exp(7, 1'b0);
    bus.in_data[0 +: DATA_W]        = 64'h8;
    bus.in_crc[0 +: CRC_W]          = 4'hB;
    bus.in_data[7*DATA_W +: DATA_W] = 64'h4;
    bus.in_crc[7*CRC_W +: CRC_W]    = 4'h5;
    @(posedge clk); #1;
    bus.in_valid[0] = 1'b1;
    bus.in_valid[7] = 1'b1;
    @(negedge clk);
    chk("t5_grant_ch0", 128'(bus.in_ready), 128'(16'h0001));
    @(posedge clk); #1;
    bus.in_valid[0] = 1'b0;
    wait_grant(7);
    @(posedge clk); #1;
    bus.in_valid[7] = 1'b0;
    drain(60);
    chk("t5_err7", 128'(err_count[7*CNT_W +: CNT_W]), 128'(1));
    chk("t5_err0", 128'(err_count[0 +: CNT_W]), 128'(0));

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
